// File: rtl/branch_ctrl.sv
// ID-stage branch sequencer: stalls on unready operands, resolves taken/not-taken,
// produces the branch target, steps over the delay slot and keeps statistics.
module branch_ctrl #(
   parameter int CNT_W = 32
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             hold,
   input  logic             br_valid,
   input  logic [2:0]       br_type,
   input  logic             rs_ready,
   input  logic             rt_ready,
   input  logic [1:0]       AB,
   input  logic [1:0]       AZ,
   input  logic [31:0]      pc_id,
   input  logic [15:0]      imm16,
   output logic             stall,
   output logic             npc_sel,
   output logic [31:0]      target,
   output logic [CNT_W-1:0] br_cnt,
   output logic [CNT_W-1:0] taken_cnt,
   output logic [CNT_W-1:0] stall_cnt
);

   localparam logic [1:0] IDLE = 2'b00;
   localparam logic [1:0] WAIT = 2'b01;
   localparam logic [1:0] SLOT = 2'b10;

   localparam logic [1:0] GT = 2'b10;
   localparam logic [1:0] EQ = 2'b01;
   localparam logic [1:0] LT = 2'b00;

   logic [1:0] state, state_nxt;
   logic       need_rt, ready, taken, active, resolve;

   assign target = pc_id + 32'd4 + {{14{imm16[15]}}, imm16, 2'b00};

   assign need_rt = (br_type == 3'b000) || (br_type == 3'b001);
   assign ready   = rs_ready && (rt_ready || !need_rt);
   assign active  = !reset && !hold;

   always_comb begin
      taken = 1'b0;
      case (br_type)
         3'b000:  taken = (AB == EQ);
         3'b001:  taken = (AB != EQ);
         3'b010:  taken = (AZ != GT);
         3'b011:  taken = (AZ == GT);
         3'b100:  taken = (AZ == LT);
         3'b101:  taken = (AZ != LT);
         default: taken = 1'b0;
      endcase
   end

   // IDLE and WAIT behave identically for a present branch; only SLOT masks it.
   always_comb begin
      resolve   = 1'b0;
      stall     = 1'b0;
      state_nxt = IDLE;
      case (state)
         IDLE, WAIT: begin
            if (br_valid) begin
               if (ready) begin
                  resolve   = active;
                  state_nxt = SLOT;
               end else begin
                  stall     = active;
                  state_nxt = WAIT;
               end
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   assign npc_sel = resolve && taken;

   always_ff @(posedge clk) begin
      if (reset) begin
         state     <= IDLE;
         br_cnt    <= '0;
         taken_cnt <= '0;
         stall_cnt <= '0;
      end else if (!hold) begin
         state <= state_nxt;
         if (resolve) br_cnt <= br_cnt + 1'b1;
         if (npc_sel) taken_cnt <= taken_cnt + 1'b1;
         if (stall)   stall_cnt <= stall_cnt + 1'b1;
      end
   end

endmodule

// File: tb/tb_branch_ctrl.sv
// Directed bench for branch_ctrl (CNT_W=4 to exercise counter wrap); a per-cycle
// expected-response queue is drained by a separate monitor on the falling edge.
module tb_branch_ctrl;
   localparam int CW = 4;

   logic          clk = 1'b0;
   logic          reset, hold, br_valid, rs_ready, rt_ready;
   logic [2:0]    br_type;
   logic [1:0]    AB, AZ;
   logic [31:0]   pc_id;
   logic [15:0]   imm16;
   logic          stall, npc_sel;
   logic [31:0]   target;
   logic [CW-1:0] br_cnt, taken_cnt, stall_cnt;

   int checks = 0;
   int failures = 0;

   typedef struct {
      logic          st;
      logic          np;
      logic [31:0]   tg;
      logic [CW-1:0] br;
      logic [CW-1:0] tk;
      logic [CW-1:0] sc;
      int            id;
   } exp_t;

   exp_t sb[$];
   int   vid = 0;

   branch_ctrl #(.CNT_W(CW)) dut (
      .clk(clk), .reset(reset), .hold(hold), .br_valid(br_valid), .br_type(br_type),
      .rs_ready(rs_ready), .rt_ready(rt_ready), .AB(AB), .AZ(AZ), .pc_id(pc_id),
      .imm16(imm16), .stall(stall), .npc_sel(npc_sel), .target(target),
      .br_cnt(br_cnt), .taken_cnt(taken_cnt), .stall_cnt(stall_cnt)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input int id, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s vec=%0d actual=0x%0h required=0x%0h", name, id, act, exp);
      end
   endtask

   always @(negedge clk) begin
      if (sb.size() != 0) begin
         exp_t e;
         e = sb.pop_front();
         chk("stall",     e.id, {31'd0, stall},     {31'd0, e.st});
         chk("npc_sel",   e.id, {31'd0, npc_sel},   {31'd0, e.np});
         chk("target",    e.id, target,             e.tg);
         chk("br_cnt",    e.id, {28'd0, br_cnt},    {28'd0, e.br});
         chk("taken_cnt", e.id, {28'd0, taken_cnt}, {28'd0, e.tk});
         chk("stall_cnt", e.id, {28'd0, stall_cnt}, {28'd0, e.sc});
      end
   end

   // Drive one cycle of inputs and queue the outputs expected during that cycle.
   // Counter expectations are the values before this cycle's edge.
   task automatic vec(input logic rst, input logic hld, input logic bv, input logic [2:0] bt,
                      input logic rsr, input logic rtr, input logic [1:0] ab, input logic [1:0] az,
                      input logic [15:0] imm,
                      input logic es, input logic en, input logic [31:0] et,
                      input int ebr, input int etk, input int esc);
      exp_t e;
      reset = rst; hold = hld; br_valid = bv; br_type = bt;
      rs_ready = rsr; rt_ready = rtr; AB = ab; AZ = az;
      pc_id = 32'h0000_3000; imm16 = imm;
      e.st = es; e.np = en; e.tg = et;
      e.br = CW'(ebr); e.tk = CW'(etk); e.sc = CW'(esc);
      e.id = vid;
      vid++;
      sb.push_back(e);
      @(posedge clk);
      #1;
   endtask

   localparam logic [31:0] T0 = 32'h0000_3004;

   initial begin
      int i;
      reset = 1'b1; hold = 1'b0; br_valid = 1'b0; br_type = 3'd0;
      rs_ready = 1'b0; rt_ready = 1'b0; AB = 2'b00; AZ = 2'b00;
      pc_id = 32'h0000_3000; imm16 = 16'h0000;
      @(posedge clk);
      #1;
      //   rst hld bv type    rs rt AB     AZ     imm       st np target        br tk sc
      vec(1, 0, 1, 3'b000, 1, 1, 2'b01, 2'b00, 16'h0000, 0, 0, T0,            0, 0, 0); // reset masks
      vec(0, 0, 1, 3'b000, 1, 1, 2'b01, 2'b00, 16'h0004, 0, 1, 32'h0000_3014, 0, 0, 0); // beq taken
      vec(0, 0, 1, 3'b000, 1, 1, 2'b01, 2'b00, 16'h0000, 0, 0, T0,            1, 1, 0); // slot ignores
      vec(0, 0, 1, 3'b001, 1, 0, 2'b01, 2'b00, 16'h0000, 1, 0, T0,            1, 1, 0); // bne wait
      vec(0, 0, 1, 3'b001, 1, 0, 2'b01, 2'b00, 16'h0000, 1, 0, T0,            1, 1, 1);
      vec(0, 0, 1, 3'b001, 1, 1, 2'b01, 2'b00, 16'h0000, 0, 0, T0,            1, 1, 2); // bne not taken
      vec(0, 0, 0, 3'b000, 0, 0, 2'b00, 2'b00, 16'h0000, 0, 0, T0,            2, 1, 2);
      vec(0, 0, 1, 3'b101, 1, 0, 2'b00, 2'b01, 16'hFFFF, 0, 1, 32'h0000_3000, 2, 1, 2); // bgez, no rt
      vec(0, 0, 0, 3'b000, 0, 0, 2'b00, 2'b00, 16'h0000, 0, 0, T0,            3, 2, 2);
      vec(0, 0, 1, 3'b010, 0, 0, 2'b00, 2'b00, 16'h0000, 1, 0, T0,            3, 2, 2); // blez wait
      vec(0, 1, 1, 3'b010, 0, 0, 2'b00, 2'b00, 16'h0000, 0, 0, T0,            3, 2, 3); // hold
      vec(0, 1, 1, 3'b010, 0, 0, 2'b00, 2'b00, 16'h0000, 0, 0, T0,            3, 2, 3);
      vec(0, 1, 1, 3'b010, 1, 0, 2'b00, 2'b00, 16'h0000, 0, 0, T0,            3, 2, 3);
      vec(0, 0, 1, 3'b010, 1, 0, 2'b00, 2'b00, 16'h0000, 0, 1, T0,            3, 2, 3); // hold drops
      vec(0, 0, 0, 3'b000, 0, 0, 2'b00, 2'b00, 16'h0000, 0, 0, T0,            4, 3, 3);
      vec(0, 0, 1, 3'b110, 1, 1, 2'b01, 2'b01, 16'h0000, 0, 0, T0,            4, 3, 3); // reserved
      vec(0, 0, 0, 3'b000, 0, 0, 2'b00, 2'b00, 16'h0000, 0, 0, T0,            5, 3, 3);
      vec(0, 0, 1, 3'b100, 1, 0, 2'b00, 2'b10, 16'h0000, 0, 0, T0,            5, 3, 3); // bltz NT
      vec(0, 0, 0, 3'b000, 0, 0, 2'b00, 2'b00, 16'h0000, 0, 0, T0,            6, 3, 3);
      vec(0, 0, 1, 3'b011, 1, 0, 2'b00, 2'b10, 16'h0000, 0, 1, T0,            6, 3, 3); // bgtz T
      vec(0, 0, 0, 3'b000, 0, 0, 2'b00, 2'b00, 16'h0000, 0, 0, T0,            7, 4, 3);
      vec(0, 0, 1, 3'b000, 1, 0, 2'b01, 2'b00, 16'h0000, 1, 0, T0,            7, 4, 3); // beq wait
      vec(0, 0, 0, 3'b000, 1, 1, 2'b01, 2'b00, 16'h0000, 0, 0, T0,            7, 4, 4); // br_valid drop
      vec(0, 0, 1, 3'b000, 1, 1, 2'b10, 2'b00, 16'h0000, 0, 0, T0,            7, 4, 4); // beq NT in IDLE
      vec(0, 0, 0, 3'b000, 0, 0, 2'b00, 2'b00, 16'h0000, 0, 0, T0,            8, 4, 4);
      // Twelve taken beqs: br 8->20 (wraps to 4), taken 4->16 (wraps to 0).
      for (i = 0; i < 12; i++) begin
         vec(0, 0, 1, 3'b000, 1, 1, 2'b01, 2'b00, 16'h0000, 0, 1, T0, (8 + i) % 16, (4 + i) % 16, 4);
         vec(0, 0, 0, 3'b000, 0, 0, 2'b00, 2'b00, 16'h0000, 0, 0, T0, (9 + i) % 16, (5 + i) % 16, 4);
      end
      vec(0, 0, 1, 3'b000, 0, 1, 2'b01, 2'b00, 16'h0000, 1, 0, T0,            4, 0, 4); // into WAIT
      vec(1, 0, 1, 3'b000, 1, 1, 2'b01, 2'b00, 16'h0000, 0, 0, T0,            4, 0, 5); // reset in WAIT
      vec(0, 0, 1, 3'b000, 1, 1, 2'b00, 2'b00, 16'h0000, 0, 0, T0,            0, 0, 0); // IDLE resolve NT
      vec(0, 0, 1, 3'b000, 0, 0, 2'b01, 2'b00, 16'h0000, 0, 0, T0,            1, 0, 0); // slot, no stall
      vec(0, 0, 0, 3'b000, 0, 0, 2'b00, 2'b00, 16'h0000, 0, 0, T0,            1, 0, 0);
      for (i = 0; i < 20 && sb.size() != 0; i++) @(posedge clk);
      if (sb.size() != 0) begin
         failures++;
         $display("FAIL drain pending=%0d required=0", sb.size());
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/branch_ctrl.md
Name: branch_ctrl

Overview:
- ID-stage branch sequencer for the pipelined MIPS core.
- Decides whether the signed comparator result can be trusted this cycle. Stalls ID while branch operands are still in flight from EX/MEM.
- Turns the comparator flags into a taken/not-taken decision and the branch target.
- Tracks the delay slot and keeps branch statistics counters.

Parameters:
CNT_W, 32, width of the statistics counters (wrap modulo 2^CNT_W)

Ports:
clk  in  1  system clock, all state on rising edge
reset  in  1  synchronous, active-high; clears all state
hold  in  1  external pipeline freeze (mult/div busy etc.); FSM and counters frozen
br_valid  in  1  instruction in ID is a branch
br_type  in  3  000 beq, 001 bne, 010 blez, 011 bgtz, 100 bltz, 101 bgez, 110/111 reserved
rs_ready  in  1  rs value at comparator input is final (forwarding unit)
rt_ready  in  1  rt value at comparator input is final
AB  in  2  comparator rs vs rt: 10 greater, 01 equal, 00 less (signed)
AZ  in  2  comparator rs vs 0: 10 greater, 01 equal, 00 less (signed)
pc_id  in  32  address of the branch in ID
imm16  in  16  branch offset field
stall  out  1  hold IF/ID, bubble into EX
npc_sel  out  1  1 = next PC is target (taken, decided this cycle)
target  out  32  pc_id + 4 + (sign_ext(imm16) << 2), mod 2^32
br_cnt  out  CNT_W  branches resolved
taken_cnt  out  CNT_W  branches resolved taken
stall_cnt  out  CNT_W  cycles stall was asserted

Behaviour:
- States: IDLE, WAIT, SLOT; 2-bit state register; reset → IDLE, all counters 0.
- stall and npc_sel are combinational from state and inputs. Both are forced 0 while reset=1 or hold=1.
- target is always combinational.
- need_rt = (br_type is beq or bne). ready = rs_ready && (rt_ready || !need_rt).
- Taken decode:
  - beq: AB==01
  - bne: AB!=01
  - blez: AZ!=10
  - bgtz: AZ==10
  - bltz: AZ==00
  - bgez: AZ!=00
  - reserved types: never taken, but still counted as resolved.
- "resolve" = decision made this cycle. npc_sel = taken; br_cnt+1; taken_cnt+1 if taken. Latency 0 cycles after ready.
- IDLE:
  - br_valid && ready: resolve, stall=0, → SLOT.
  - br_valid && !ready: stall=1, → WAIT.
  - Otherwise stay in IDLE.
- WAIT:
  - ready: resolve, stall=0, → SLOT.
  - Else stall=1, stay in WAIT.
  - br_valid dropping in WAIT is not legal (ID is frozen). If it occurs anyway: → IDLE, no resolve.
- SLOT:
  - The delay-slot instruction is in ID. br_valid is ignored (branch in a delay slot is not supported): no stall, no resolve, npc_sel=0.
  - → IDLE unconditionally.
- hold=1: state, counters unchanged; stall=npc_sel=0 (hold owner already freezes pipe). Decision is re-evaluated when hold drops.
- stall_cnt increments each cycle stall=1 (not during hold/reset).
- Counters wrap to 0 past 2^CNT_W-1, no saturation.
- reset during WAIT or SLOT: next cycle IDLE, counters 0, no resolve in the reset cycle.
- Operand-ready and flag inputs are sampled only in the resolve cycle. Flag values in stall cycles are don't-care.

Test Plan:
- beq, ready, AB=01, pc_id=0x00003000, imm16=0x0004 → same cycle npc_sel=1, target=0x00003014, stall=0; next cycle state SLOT; br_cnt=1, taken_cnt=1.
- bne, rs_ready=1, rt_ready=0 for 2 cycles, then ready with AB=01 → stall=1 for 2 cycles, stall_cnt=2, then npc_sel=0, br_cnt=1, taken_cnt=0.
- bgez, rt_ready=0, rs_ready=1, AZ=01 → no stall (rt not needed), npc_sel=1; imm16=0xFFFF, pc_id=0x00003000 → target=0x00003000.
- Branch, then br_valid=1 again in the SLOT cycle → stall=0, npc_sel=0, br_cnt unchanged; a following branch in IDLE resolves normally.
- WAIT with hold=1 for 3 cycles → stall=0, stall_cnt frozen, state WAIT. Hold drops with ready and blez AZ=00 → npc_sel=1.
- Preload CNT_W=4 bench: 16 taken branches → br_cnt, taken_cnt wrap to 0. reset asserted in WAIT → next cycle stall=0, counters 0, state IDLE.
